// File: rtl/countdown_pkg.sv
// Shared definitions for the countdown timer: the FSM state encoding and the
// default counter width.  The encoding is kept here so that any block that
// needs to decode timer state uses the same values.
package countdown_pkg;

   localparam int DEFAULT_WIDTH = 8;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_RUN    = 2'd1;
   localparam logic [1:0] ST_EXPIRE = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE   = ST_IDLE,
      S_RUN    = ST_RUN,
      S_EXPIRE = ST_EXPIRE
   } timer_state_t;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter.  A start value N is taken over a valid/ready
// handshake while idle; the count then drops by one on every tick and done
// pulses for one cycle once zero is reached.  abort cancels a running count.
// Optional feature macro: COUNTDOWN_AUTO_RELOAD_EN -- when defined, the timer
// restarts from the last loaded value after every expiry and only abort
// returns it to idle.
module countdown_timer
   import countdown_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_value,
   input  logic             tick,
   input  logic             abort,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done
);

   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
   localparam logic [WIDTH-1:0] ZERO = '0;

   timer_state_t state;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
   logic [WIDTH-1:0] reloadReg;
`endif

   // Status outputs are pure decodes of the state register, so none of them
   // depends combinationally on an input.
   assign load_ready = (state == S_IDLE);
   assign busy       = (state != S_IDLE);
   assign done       = (state == S_EXPIRE);

   // Timer FSM together with the counter: abort wins over everything else
   // outside idle, and the count is only decremented from values of one or
   // more so it can never wrap.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
         count <= ZERO;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
         reloadReg <= ZERO;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (load_valid) begin
                  count <= load_value;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                  reloadReg <= load_value;
`endif
                  state <= (load_value == ZERO) ? S_EXPIRE : S_RUN;
               end
            end
            S_RUN: begin
               if (abort) begin
                  count <= ZERO;
                  state <= S_IDLE;
               end else if (tick) begin
                  count <= count - ONE;
                  if (count == ONE) begin
                     state <= S_EXPIRE;
                  end
               end
            end
            S_EXPIRE: begin
               if (abort) begin
                  count <= ZERO;
                  state <= S_IDLE;
               end else begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                  if (reloadReg != ZERO) begin
                     count <= reloadReg;
                     state <= S_RUN;
                  end
`else
                  state <= S_IDLE;
`endif
               end
            end
            default: begin
               count <= ZERO;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer.  Inputs change just after a falling
// edge and outputs are sampled on the falling edge, half a cycle away from
// the rising edge that updates them.
module tb_countdown_timer;

   localparam int WIDTH = 8;

   logic             clock;
   logic             reset;
   logic             load_valid;
   logic             load_ready;
   logic [WIDTH-1:0] load_value;
   logic             tick;
   logic             abort;
   logic [WIDTH-1:0] count;
   logic             busy;
   logic             done;

   int passCount;
   int totalCount;

   countdown_timer #(.WIDTH(WIDTH)) dut (
      .clock      (clock),
      .reset      (reset),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_value (load_value),
      .tick       (tick),
      .abort      (abort),
      .count      (count),
      .busy       (busy),
      .done       (done)
   );

   // Free-running 10 ns clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Hard stop in case the sequence ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL timeout observed=running expected=finished");
      $fatal(1, "[TB] simulation time limit reached");
   end

   task automatic checkOutput(input string tag, input int observed, input int expected);
      totalCount++;
      assert (observed === expected) passCount++;
      else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
   endtask

   task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] n,
                                input logic t, input logic a);
      load_valid = v;
      load_value = n;
      tick       = t;
      abort      = a;
   endtask

   task automatic stepCycle();
      @(negedge clock);
   endtask

   task automatic checkStatus(input string tag, input int c, input int b,
                              input int d, input int r);
      checkOutput({tag, ".count"}, int'(count), c);
      checkOutput({tag, ".busy"}, int'(busy), b);
      checkOutput({tag, ".done"}, int'(done), d);
      checkOutput({tag, ".ready"}, int'(load_ready), r);
   endtask

   initial begin
      passCount  = 0;
      totalCount = 0;
      reset      = 1'b0;
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0);

      // Power-on reset values.
      repeat (2) stepCycle();
      checkStatus("por", 0, 0, 0, 1);
      reset = 1'b1;
      stepCycle();
      checkStatus("idle", 0, 0, 0, 1);

      // Asynchronous reset in the middle of a count of 8, hit at count 5.
      applyStimulus(1'b1, 8'd8, 1'b1, 1'b0);
      stepCycle();
      checkStatus("rst.load", 8, 1, 0, 0);
      applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
      repeat (3) stepCycle();
      checkOutput("rst.pre", int'(count), 5);
      #2 reset = 1'b0;
      #1 checkStatus("rst.async", 0, 0, 0, 1);
      stepCycle();
      checkOutput("rst.nodone", int'(done), 0);
      reset = 1'b1;
      stepCycle();
      checkStatus("rst.after", 0, 0, 0, 1);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
      // Auto-reload with N=2: done every third cycle, never ready until abort.
      applyStimulus(1'b1, 8'd2, 1'b1, 1'b0);
      stepCycle();
      applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
      checkStatus("ar.e0", 2, 1, 0, 0);
      stepCycle();
      checkStatus("ar.e1", 1, 1, 0, 0);
      stepCycle();
      checkStatus("ar.e2", 0, 1, 1, 0);
      stepCycle();
      checkStatus("ar.e3", 2, 1, 0, 0);
      stepCycle();
      checkStatus("ar.e4", 1, 1, 0, 0);
      stepCycle();
      checkStatus("ar.e5", 0, 1, 1, 0);
      stepCycle();
      checkStatus("ar.e6", 2, 1, 0, 0);
      applyStimulus(1'b0, 8'd0, 1'b1, 1'b1);
      stepCycle();
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0);
      checkStatus("ar.abort", 0, 0, 0, 1);
      stepCycle();
      checkStatus("ar.idle", 0, 0, 0, 1);
`else
      // Basic count from 3 with tick held high.
      applyStimulus(1'b1, 8'd3, 1'b1, 1'b0);
      stepCycle();
      applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
      checkStatus("n3.e0", 3, 1, 0, 0);
      stepCycle();
      checkStatus("n3.e1", 2, 1, 0, 0);
      stepCycle();
      checkStatus("n3.e2", 1, 1, 0, 0);
      stepCycle();
      checkStatus("n3.e3", 0, 1, 1, 0);
      stepCycle();
      checkStatus("n3.e4", 0, 0, 0, 1);

      // Load while not ready is ignored: offer 7 during the expiry of N=0.
      applyStimulus(1'b1, 8'd0, 1'b1, 1'b0);
      stepCycle();
      applyStimulus(1'b1, 8'd7, 1'b1, 1'b0);
      checkStatus("n0.e0", 0, 1, 1, 0);
      stepCycle();
      applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
      checkStatus("n0.e1", 0, 0, 0, 1);

      // Largest start value: 255 counts down without wrapping.
      applyStimulus(1'b1, 8'd255, 1'b1, 1'b0);
      stepCycle();
      applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
      checkStatus("n255.e0", 255, 1, 0, 0);
      for (int k = 1; k < 255; k++) begin
         stepCycle();
         checkOutput("n255.count", int'(count), 255 - k);
         checkOutput("n255.done", int'(done), 0);
      end
      stepCycle();
      checkStatus("n255.exp", 0, 1, 1, 0);
      stepCycle();
      checkStatus("n255.idle", 0, 0, 0, 1);

      // Tick gating: N=4, tick on every third edge.
      applyStimulus(1'b1, 8'd4, 1'b0, 1'b0);
      stepCycle();
      checkStatus("gate.e0", 4, 1, 0, 0);
      for (int k = 1; k <= 12; k++) begin
         applyStimulus(1'b0, 8'd0, (k % 3) == 0, 1'b0);
         stepCycle();
         checkOutput("gate.count", int'(count), 4 - k / 3);
         checkOutput("gate.done", int'(done), (k == 12) ? 1 : 0);
      end
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0);
      stepCycle();
      checkStatus("gate.idle", 0, 0, 0, 1);

      // Abort at count 1 together with a tick: no done, straight to idle.
      applyStimulus(1'b1, 8'd10, 1'b1, 1'b0);
      stepCycle();
      applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
      checkStatus("ab.e0", 10, 1, 0, 0);
      repeat (9) stepCycle();
      checkStatus("ab.pre", 1, 1, 0, 0);
      applyStimulus(1'b0, 8'd0, 1'b1, 1'b1);
      stepCycle();
      applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
      checkStatus("ab.post", 0, 0, 0, 1);
      for (int k = 0; k < 3; k++) begin
         stepCycle();
         checkOutput("ab.nodone", int'(done), 0);
      end

      // Abort while idle does not block a same-cycle load.
      applyStimulus(1'b1, 8'd5, 1'b0, 1'b1);
      stepCycle();
      checkStatus("abidle.load", 5, 1, 0, 0);
      applyStimulus(1'b0, 8'd0, 1'b1, 1'b1);
      stepCycle();
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0);
      checkStatus("abidle.abort", 0, 0, 0, 1);
`endif

      $display("[TB] %0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule
